// File: rtl/pcore_fetch_pkg.sv
// Shared types for the fetch front end: queue entry, icache request/response
// bundles, fetch FSM states, the canonical NOP and the compressed-parcel test.
package pcore_fetch_pkg;

  localparam int unsigned FB_XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]        data;
    logic [FB_XLEN-1:0] pc;
    logic               fault;
  } type_fb_entry_s;

  typedef struct packed {
    logic               valid;
    logic [FB_XLEN-1:0] addr;
  } type_fb_req_s;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        fault;
  } type_fb_resp_s;

  typedef enum logic [0:0] {
    StFetch,
    StFaultHold
  } type_fb_state_e;

  function automatic logic is_compressed(input logic [15:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fb_queue.sv
// Circular FIFO of fetch words for the fetch buffer.
// Ports: clk/rst (async active-high), flush_i clears the queue (wins over
// push/pop), push_i/push_entry_i write at the tail, pop_i drops the head,
// head_o is the head entry, next_lo_o/next_fault_o expose the low parcel and
// fault of the entry after the head, count_o is the occupancy.
module fb_queue
  import pcore_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  type_fb_entry_s         push_entry_i,
  input  logic                   pop_i,
  output type_fb_entry_s         head_o,
  output logic [15:0]            next_lo_o,
  output logic                   next_fault_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  type_fb_entry_s   mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + 1'b1;
      if (pop_i)  head_d = head_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[tail_q] <= push_entry_i;
  end

  assign head_nxt     = head_q + 1'b1;
  assign head_o       = mem_q[head_q];
  assign next_lo_o    = mem_q[head_nxt].data[15:0];
  assign next_fault_o = mem_q[head_nxt].fault;
  assign count_o      = count_q;

`ifndef SYNTHESIS
  // The credit rule in the parent must make these impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && !flush_i && count_q == CNT_W'(DEPTH)));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(pop_i && !flush_i && count_q == '0));
`endif

endmodule

// File: rtl/fetch_buffer.sv
// Prefetch queue and instruction realigner between the icache and ID.
// Ports: req_* issue word-aligned icache fetches (req_kill_o mirrors redirect),
// resp_* return words in request order, redirect_* restart fetch at a new PC,
// instr_* present one 16/32-bit instruction per handshake (faults become a NOP
// with instr_fault_o), count_o shows queue occupancy.
// XLEN must equal FB_XLEN from the package (entry PC width).
module fetch_buffer
  import pcore_fetch_pkg::*;
#(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] PC_RESET        = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   req_valid_o,
  output logic [XLEN-1:0]        req_addr_o,
  input  logic                   req_ready_i,
  input  logic                   resp_valid_i,
  input  logic [31:0]            resp_data_i,
  input  logic                   resp_fault_i,
  input  logic                   redirect_i,
  input  logic [XLEN-1:0]        redirect_pc_i,
  output logic                   req_kill_o,
  output logic                   instr_valid_o,
  output logic [31:0]            instr_o,
  output logic [XLEN-1:0]        instr_pc_o,
  output logic                   instr_is_comp_o,
  output logic                   instr_fault_o,
  input  logic                   instr_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned CNT_W1 = CNT_W + 1;

  type_fb_state_e  state_q, state_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic            head_half_q, head_half_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d, discard_q, discard_d, count;
  logic [CNT_W:0]  in_use;

  type_fb_req_s   req;
  type_fb_resp_s  resp;
  type_fb_entry_s head, push_entry;
  logic [15:0]    next_lo, parcel0;
  logic           next_fault, comp, push, pop, req_fire, consume;
  logic           unused_pc0;

  assign unused_pc0 = redirect_pc_i[0];
  assign resp = '{valid: resp_valid_i, data: resp_data_i, fault: resp_fault_i};

  // Credit: queued words plus words in flight may never exceed the queue.
  assign in_use = {1'b0, count} + {1'b0, outstanding_q};

  always_comb begin
    req.valid = ~rst && (state_q == StFetch) && (in_use < CNT_W1'(DEPTH))
                && (outstanding_q < CNT_W'(MAX_OUTSTANDING)) && ~redirect_i;
    req.addr  = fetch_addr_q;
  end

  assign req_valid_o = req.valid;
  assign req_addr_o  = req.addr;
  assign req_kill_o  = redirect_i;
  assign req_fire    = req.valid & req_ready_i;

  // Responses are dropped while stale ones drain, and always in a redirect cycle.
  assign push = resp.valid && (discard_q == '0) && ~redirect_i;

  always_comb begin
    push_entry.data  = resp.data;
    push_entry.pc    = FB_XLEN'(resp_pc_q);
    push_entry.fault = resp.fault;
  end

  fb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect_i),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .next_lo_o    (next_lo),
    .next_fault_o (next_fault),
    .count_o      (count)
  );

  assign count_o = count;

  // Realigner
  assign parcel0 = head_half_q ? head.data[31:16] : head.data[15:0];
  assign comp    = is_compressed(parcel0);

  always_comb begin
    instr_valid_o   = 1'b0;
    instr_o         = '0;
    instr_is_comp_o = 1'b0;
    instr_fault_o   = 1'b0;
    if (count != '0) begin
      if (head.fault) begin
        // Faulted word data is meaningless; report it without waiting for more.
        instr_valid_o = 1'b1;
        instr_fault_o = 1'b1;
      end else if (comp) begin
        instr_valid_o   = 1'b1;
        instr_o         = {16'h0000, parcel0};
        instr_is_comp_o = 1'b1;
      end else if (!head_half_q) begin
        instr_valid_o = 1'b1;
        instr_o       = head.data;
      end else if (count >= CNT_W'(2)) begin
        instr_valid_o = 1'b1;
        instr_o       = {next_lo, parcel0};
        instr_fault_o = next_fault;
      end
    end
    if (instr_fault_o) instr_o = INSTR_NOP;
    if (redirect_i) instr_valid_o = 1'b0;
  end

  assign instr_pc_o = XLEN'(head.pc) + XLEN'({head_half_q, 1'b0});
  assign consume    = instr_valid_o & instr_ready_i;

  always_comb begin
    pop         = 1'b0;
    head_half_d = head_half_q;
    if (redirect_i) begin
      head_half_d = redirect_pc_i[1];
    end else if (consume) begin
      if (head.fault) begin
        pop         = 1'b1;
        head_half_d = 1'b0;
      end else if (comp) begin
        head_half_d = ~head_half_q;
        pop         = head_half_q;
      end else begin
        // Aligned keeps half 0; a straddle leaves its upper parcel in the new head.
        pop = 1'b1;
      end
    end
  end

  always_comb begin
    fetch_addr_d  = fetch_addr_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    state_d       = state_q;
    if (req_fire)   outstanding_d = outstanding_d + 1'b1;
    if (resp.valid) outstanding_d = outstanding_d - 1'b1;
    if (redirect_i) begin
      fetch_addr_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      resp_pc_d    = {redirect_pc_i[XLEN-1:2], 2'b00};
      discard_d    = outstanding_q - CNT_W'(resp.valid);
      state_d      = StFetch;
    end else begin
      if (req_fire) fetch_addr_d = fetch_addr_q + XLEN'(4);
      if (push)     resp_pc_d    = resp_pc_q + XLEN'(4);
      if (resp.valid && discard_q != '0) discard_d = discard_q - 1'b1;
      case (state_q)
        StFetch:     if (push && resp.fault) state_d = StFaultHold;
        StFaultHold: state_d = StFaultHold;
        default:     state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StFetch;
      fetch_addr_q  <= PC_RESET;
      resp_pc_q     <= PC_RESET;
      head_half_q   <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      resp_pc_q     <= resp_pc_d;
      head_half_q   <= head_half_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;
  import pcore_fetch_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] PC_RESET = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_o, req_ready_i = 1'b1;
  logic [31:0] req_addr_o;
  logic        resp_valid_i = 1'b0, resp_fault_i = 1'b0;
  logic [31:0] resp_data_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        req_kill_o, instr_valid_o, instr_is_comp_o, instr_fault_o;
  logic [31:0] instr_o, instr_pc_o;
  logic        instr_ready_i = 1'b0;
  logic [2:0]  count_o;

  fetch_buffer #(
    .XLEN            (32),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (2),
    .PC_RESET        (PC_RESET)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_o     (req_valid_o),
    .req_addr_o      (req_addr_o),
    .req_ready_i     (req_ready_i),
    .resp_valid_i    (resp_valid_i),
    .resp_data_i     (resp_data_i),
    .resp_fault_i    (resp_fault_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .req_kill_o      (req_kill_o),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_is_comp_o (instr_is_comp_o),
    .instr_fault_o   (instr_fault_o),
    .instr_ready_i   (instr_ready_i),
    .count_o         (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_checks = 0;
  int          n_fail = 0;
  int          req_cnt = 0;
  int          kill_cnt = 0;
  bit          stall = 1'b0;
  bit          fault_en = 1'b0;
  logic [31:0] fault_addr = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_instr(input logic [31:0] instr, input logic [31:0] pc,
                              input logic comp, input logic fault);
    exp_t e;
    e.instr = instr; e.pc = pc; e.comp = comp; e.fault = fault;
    exp_q.push_back(e);
  endtask

  // One-cycle in-order icache; stall holds responses back.
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (!rst && req_valid_o && req_ready_i) begin
        pend_q.push_back(req_addr_o);
        req_cnt++;
      end
      @(posedge clk);
      #1;
      if (!stall && pend_q.size() != 0) begin
        a            = pend_q.pop_front();
        resp_valid_i = 1'b1;
        resp_data_i  = mem_rd(a);
        resp_fault_i = fault_en && (a == fault_addr);
      end else begin
        resp_valid_i = 1'b0;
        resp_data_i  = '0;
        resp_fault_i = 1'b0;
      end
    end
  end

  // Monitor: every consumed instruction is checked against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (req_kill_o) kill_cnt++;
      if (!rst && instr_valid_o && instr_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instr: got %h @%h, required none", instr_o, instr_pc_o);
        end else begin
          e = exp_q.pop_front();
          check("instr", instr_o, e.instr);
          check("instr_pc", instr_pc_o, e.pc);
          check("is_comp", {31'b0, instr_is_comp_o}, {31'b0, e.comp});
          check("fault", {31'b0, instr_fault_o}, {31'b0, e.fault});
        end
      end
    end
  end

  task automatic do_redirect(input logic [31:0] pc, input logic rdy);
    @(posedge clk);
    #1;
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    instr_ready_i = rdy;
    @(negedge clk);
    check("kill", {31'b0, req_kill_o}, 32'd1);
    check("redir_no_instr", {31'b0, instr_valid_o}, 32'd0);
    check("redir_no_req", {31'b0, req_valid_o}, 32'd0);
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    check("flush_count", {29'b0, count_o}, 32'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d instructions pending, required 0", exp_q.size());
      exp_q.delete();
    end
    instr_ready_i = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int base;
    int k0;
    // Reset
    repeat (2) @(negedge clk);
    check("rst_req_valid", {31'b0, req_valid_o}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rst_count", {29'b0, count_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("first_req_valid", {31'b0, req_valid_o}, 32'd1);
    check("first_req_addr", req_addr_o, PC_RESET);
    repeat (12) @(negedge clk);

    // 1: aligned 32-bit pair plus first-instruction latency
    mem[32'h100] = 32'h0000_0013;
    mem[32'h104] = 32'h0010_0093;
    expect_instr(32'h0000_0013, 32'h100, 1'b0, 1'b0);
    expect_instr(32'h0010_0093, 32'h104, 1'b0, 1'b0);
    do_redirect(32'h100, 1'b1);
    @(negedge clk);
    check("lat_c1", {31'b0, instr_valid_o}, 32'd0);
    @(negedge clk);
    check("lat_c2", {31'b0, instr_valid_o}, 32'd0);
    @(negedge clk);
    check("lat_c3", {31'b0, instr_valid_o}, 32'd1);
    wait_drain();

    // 2: start on an upper half, compressed parcels
    settle();
    mem[32'h100] = 32'h4505_0013;
    mem[32'h104] = 32'h0001_4581;
    expect_instr(32'h0000_4505, 32'h102, 1'b1, 1'b0);
    expect_instr(32'h0000_4581, 32'h104, 1'b1, 1'b0);
    expect_instr(32'h0000_0001, 32'h106, 1'b1, 1'b0);
    do_redirect(32'h102, 1'b1);
    wait_drain();

    // 3: straddling instruction waits for its second word
    settle();
    mem[32'h200] = 32'h0093_0001;
    mem[32'h204] = 32'h0000_0010;
    expect_instr(32'h0000_0001, 32'h200, 1'b1, 1'b0);
    expect_instr(32'h0010_0093, 32'h202, 1'b0, 1'b0);
    @(negedge clk);
    stall = 1'b1;
    do_redirect(32'h200, 1'b1);
    repeat (3) @(negedge clk);
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    repeat (2) @(negedge clk);
    check("straddle_wait1", {31'b0, instr_valid_o}, 32'd0);
    @(negedge clk);
    check("straddle_wait2", {31'b0, instr_valid_o}, 32'd0);
    stall = 1'b0;
    wait_drain();

    // 4: ID stalled, queue fills exactly
    settle();
    do_redirect(32'h400, 1'b0);
    base = req_cnt;
    repeat (12) @(negedge clk);
    check("full_count", {29'b0, count_o}, DEPTH);
    check("full_no_req", {31'b0, req_valid_o}, 32'd0);
    check("full_req_total", req_cnt - base, DEPTH);

    // 5: redirect with two requests in flight
    settle();
    mem[32'h280] = 32'h1111_1111;
    mem[32'h284] = 32'h2222_2221;
    mem[32'h300] = 32'h00a0_0513;
    mem[32'h304] = 32'h0000_0013;
    @(negedge clk);
    stall = 1'b1;
    do_redirect(32'h280, 1'b0);
    base = req_cnt;
    repeat (4) @(negedge clk);
    check("max_outst_block", {31'b0, req_valid_o}, 32'd0);
    check("max_outst_reqs", req_cnt - base, 32'd2);
    expect_instr(32'h00a0_0513, 32'h300, 1'b0, 1'b0);
    expect_instr(32'h0000_0013, 32'h304, 1'b0, 1'b0);
    k0 = kill_cnt;
    do_redirect(32'h300, 1'b1);
    @(negedge clk);
    stall = 1'b0;
    wait_drain();
    check("kill_pulses", kill_cnt - k0, 32'd1);

    // 6: fault on second word, hold until redirect
    settle();
    mem[32'h500] = 32'h0000_0013;
    mem[32'h504] = 32'hdead_beef;
    fault_en   = 1'b1;
    fault_addr = 32'h504;
    expect_instr(32'h0000_0013, 32'h500, 1'b0, 1'b0);
    expect_instr(INSTR_NOP, 32'h504, 1'b0, 1'b1);
    do_redirect(32'h500, 1'b1);
    wait_drain();
    repeat (4) @(negedge clk);
    base = req_cnt;
    repeat (8) @(negedge clk);
    check("hold_no_reqs", req_cnt - base, 32'd0);
    check("hold_req_valid", {31'b0, req_valid_o}, 32'd0);
    fault_en = 1'b0;
    mem[32'h600] = 32'h0010_0093;
    expect_instr(32'h0010_0093, 32'h600, 1'b0, 1'b0);
    do_redirect(32'h600, 1'b1);
    wait_drain();

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
